// File: rtl/addr_gen_pkg.sv
// Shared types and constants for the address generator: mode/state encodings and pointer sizes.
// Also provides the pointer increment helper used by the fetch engine.
package addr_gen_pkg;

   typedef enum logic [2:0] {
      ABS_X       = 3'd0,
      ABS_Y       = 3'd1,
      DP_X        = 3'd2,
      DP_IND      = 3'd3,
      DP_IND_Y    = 3'd4,
      DP_IND_LONG = 3'd5,
      DP_X_IND    = 3'd6,
      SR_IND_Y    = 3'd7
   } mode_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_BASE  = 3'd1,
      ST_FETCH = 3'd2,
      ST_INDEX = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   localparam int PTR_BYTES_SHORT = 2;
   localparam int PTR_BYTES_LONG  = 3;

   // In emulation direct-page-aligned mode the pointer wraps inside its page.
   function automatic logic [15:0] ptr_inc(input logic [15:0] a, input logic page_wrap);
      if (page_wrap)
         return {a[15:8], a[7:0] + 8'd1};
      return a + 16'd1;
   endfunction

endpackage

// File: rtl/addr_gen_ptr_fetch.sv
// Pointer fetch engine: reads 2 or 3 little-endian bytes from bank 0 with a req/rdy handshake.
// done pulses one EN cycle after the last byte completes; mem_req holds until each byte completes.
module addr_gen_ptr_fetch
   import addr_gen_pkg::*;
#(
   parameter int ADDR_W = 24
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              start,
   input  logic [15:0]       start_addr,
   input  logic              long_ptr,
   input  logic              page_wrap,
   input  logic              mem_rdy,
   input  logic [7:0]        mem_din,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              done,
   output logic [23:0]       ptr
);

   logic        act_q, act_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [15:0] addr_q, addr_d;
   logic [23:0] ptr_q, ptr_d;
   logic        done_q, done_d;
   logic        long_q, long_d;
   logic        wrap_q, wrap_d;
   logic [1:0]  last_idx;

   assign last_idx = long_q ? 2'(PTR_BYTES_LONG - 1) : 2'(PTR_BYTES_SHORT - 1);

   always_comb begin
      act_d  = act_q;
      cnt_d  = cnt_q;
      addr_d = addr_q;
      ptr_d  = ptr_q;
      done_d = done_q;
      long_d = long_q;
      wrap_d = wrap_q;
      if (en) begin
         done_d = 1'b0;
         if (start) begin
            act_d  = 1'b1;
            cnt_d  = 2'd0;
            addr_d = start_addr;
            ptr_d  = 24'd0;
            long_d = long_ptr;
            wrap_d = page_wrap;
         end else if (act_q && mem_rdy) begin
            case (cnt_q)
               2'd0:    ptr_d[7:0]   = mem_din;
               2'd1:    ptr_d[15:8]  = mem_din;
               default: ptr_d[23:16] = mem_din;
            endcase
            addr_d = ptr_inc(addr_q, wrap_q);
            cnt_d  = cnt_q + 2'd1;
            if (cnt_q == last_idx) begin
               act_d  = 1'b0;
               done_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         act_q  <= 1'b0;
         cnt_q  <= 2'd0;
         addr_q <= 16'd0;
         ptr_q  <= 24'd0;
         done_q <= 1'b0;
         long_q <= 1'b0;
         wrap_q <= 1'b0;
      end else begin
         act_q  <= act_d;
         cnt_q  <= cnt_d;
         addr_q <= addr_d;
         ptr_q  <= ptr_d;
         done_q <= done_d;
         long_q <= long_d;
         wrap_q <= wrap_d;
      end
   end

   assign mem_req  = act_q;
   assign mem_addr = {{(ADDR_W-16){1'b0}}, addr_q};
   assign done     = done_q;
   assign ptr      = ptr_q;

endmodule

// File: rtl/addr_gen_seq.sv
// 65816-style effective address sequencer: direct, indexed and indirect modes with pointer fetch.
// ea_valid 2 EN cycles after accept (direct) or after last byte (indirect, +1 with Y index); start ignored while busy.
module addr_gen_seq
   import addr_gen_pkg::*;
#(
   parameter int ADDR_W  = 24,
   parameter int IDX_W   = 16,
   parameter int LONG_EN = 1
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              EN,
   input  logic              start,
   input  logic [2:0]        mode,
   input  logic [15:0]       opnd,
   input  logic [IDX_W-1:0]  X,
   input  logic [IDX_W-1:0]  Y,
   input  logic [IDX_W-1:0]  D,
   input  logic [IDX_W-1:0]  S,
   input  logic [7:0]        DBR,
   input  logic              e6502,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_rdy,
   input  logic [7:0]        mem_din,
   output logic              busy,
   output logic [ADDR_W-1:0] ea,
   output logic              ea_valid,
   output logic              page_cross
);

   state_e state_q, state_d;
   mode_e  mode_q, mode_d, mode_in;
   logic [15:0] opnd_q, opnd_d, x_q, x_d, y_q, y_d, d_q, d_d, s_q, s_d;
   logic [7:0]  dbr_q, dbr_d;
   logic        e_q, e_d;
   logic [ADDR_W-1:0] res_q, res_d, ea_q, ea_d;
   logic        pc_res_q, pc_res_d, ea_valid_q, ea_valid_d, page_cross_q, page_cross_d;

   logic        is_direct, is_indexed_ind, is_long, page_wrap, fetch_start, fetch_done;
   logic [15:0] idx_sel, dp_sum, ptr_base;
   logic [8:0]  abs_pc9, ind_pc9;
   logic [32:0] abs_sum, ind_sum, dp_ext, full_ext;
   logic [23:0] ptr_w, ptr_full;

   // With LONG_EN=0 the long-pointer mode collapses onto the plain indirect mode at accept.
   assign mode_in = (mode == 3'd5 && LONG_EN == 0) ? DP_IND : mode_e'(mode);

   assign is_direct      = mode_q inside {ABS_X, ABS_Y, DP_X};
   assign is_indexed_ind = mode_q inside {DP_IND_Y, SR_IND_Y};
   assign is_long        = (mode_q == DP_IND_LONG);
   assign page_wrap      = e_q && (d_q[7:0] == 8'd0) && (mode_q inside {DP_IND, DP_IND_Y, DP_X_IND});

   assign idx_sel  = (mode_q == ABS_Y) ? y_q : x_q;
   assign abs_sum  = {9'd0, dbr_q, opnd_q} + {17'd0, idx_sel};
   assign abs_pc9  = {1'b0, opnd_q[7:0]} + {1'b0, idx_sel[7:0]};
   assign dp_sum   = d_q + {8'h00, opnd_q[7:0]} + x_q;
   assign dp_ext   = {17'd0, dp_sum};
   assign ptr_full = {is_long ? ptr_w[23:16] : dbr_q, ptr_w[15:0]};
   assign full_ext = {9'd0, ptr_full};
   assign ind_sum  = full_ext + {17'd0, y_q};
   assign ind_pc9  = {1'b0, ptr_w[7:0]} + {1'b0, y_q[7:0]};

   always_comb begin
      case (mode_q)
         DP_X_IND: ptr_base = d_q + {8'h00, opnd_q[7:0]} + x_q;
         SR_IND_Y: ptr_base = s_q + {8'h00, opnd_q[7:0]};
         default:  ptr_base = d_q + {8'h00, opnd_q[7:0]};
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (EN) begin
         case (state_q)
            ST_IDLE:  if (start) state_d = ST_BASE;
            ST_BASE:  state_d = is_direct ? ST_DONE : ST_FETCH;
            ST_FETCH: if (fetch_done) state_d = is_indexed_ind ? ST_INDEX : ST_DONE;
            ST_INDEX: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      busy        = (state_q != ST_IDLE);
      fetch_start = EN && (state_q == ST_BASE) && !is_direct;
   end

   always_comb begin
      mode_d = mode_q;  opnd_d = opnd_q;  x_d = x_q;  y_d = y_q;
      d_d = d_q;  s_d = s_q;  dbr_d = dbr_q;  e_d = e_q;
      res_d = res_q;  pc_res_d = pc_res_q;
      ea_d = ea_q;  ea_valid_d = ea_valid_q;  page_cross_d = page_cross_q;
      if (EN) begin
         ea_valid_d = 1'b0;
         case (state_q)
            ST_IDLE: if (start) begin
               mode_d = mode_in;
               opnd_d = opnd;
               x_d    = e6502 ? {8'h00, X[7:0]} : 16'(X);
               y_d    = e6502 ? {8'h00, Y[7:0]} : 16'(Y);
               d_d    = 16'(D);
               s_d    = 16'(S);
               dbr_d  = DBR;
               e_d    = e6502;
            end
            ST_BASE: begin
               if (mode_q == DP_X) begin
                  res_d    = dp_ext[ADDR_W-1:0];
                  pc_res_d = 1'b0;
               end else if (is_direct) begin
                  res_d    = abs_sum[ADDR_W-1:0];
                  pc_res_d = abs_pc9[8];
               end
            end
            ST_FETCH: if (fetch_done) begin
               res_d    = full_ext[ADDR_W-1:0];
               pc_res_d = 1'b0;
            end
            ST_INDEX: begin
               res_d    = ind_sum[ADDR_W-1:0];
               pc_res_d = ind_pc9[8];
            end
            ST_DONE: begin
               ea_d         = res_q;
               page_cross_d = pc_res_q;
               ea_valid_d   = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         mode_q <= ABS_X;  opnd_q <= '0;  x_q <= '0;  y_q <= '0;
         d_q <= '0;  s_q <= '0;  dbr_q <= '0;  e_q <= 1'b0;
         res_q <= '0;  pc_res_q <= 1'b0;
         ea_q <= '0;  ea_valid_q <= 1'b0;  page_cross_q <= 1'b0;
      end else begin
         mode_q <= mode_d;  opnd_q <= opnd_d;  x_q <= x_d;  y_q <= y_d;
         d_q <= d_d;  s_q <= s_d;  dbr_q <= dbr_d;  e_q <= e_d;
         res_q <= res_d;  pc_res_q <= pc_res_d;
         ea_q <= ea_d;  ea_valid_q <= ea_valid_d;  page_cross_q <= page_cross_d;
      end
   end

   addr_gen_ptr_fetch #(.ADDR_W(ADDR_W)) u_fetch (
      .clk        (CLK),
      .rst_n      (RST_N),
      .en         (EN),
      .start      (fetch_start),
      .start_addr (ptr_base),
      .long_ptr   (is_long),
      .page_wrap  (page_wrap),
      .mem_rdy    (mem_rdy),
      .mem_din    (mem_din),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .done       (fetch_done),
      .ptr        (ptr_w)
   );

   assign ea         = ea_q;
   assign ea_valid   = ea_valid_q;
   assign page_cross = page_cross_q;

endmodule

// File: tb/tb_addr_gen_seq.sv
// Directed bench for addr_gen_seq: vector table for each addressing mode plus
// hand sequences for enable gating, memory stalls with ignored start, and reset mid-fetch.
module tb_addr_gen_seq;

   logic        CLK = 1'b0;
   logic        RST_N, EN, start, e6502, mem_req, mem_rdy, busy, ea_valid, page_cross;
   logic [2:0]  mode;
   logic [15:0] opnd, X, Y, D, S;
   logic [7:0]  DBR, mem_din;
   logic [23:0] mem_addr, ea;

   logic [7:0]  mem [65536];
   logic [15:0] rd_log [$];
   int n_checks = 0;
   int n_errors = 0;

   always #5 CLK = ~CLK;

   addr_gen_seq #(.ADDR_W(24), .IDX_W(16), .LONG_EN(1)) dut (
      .CLK(CLK), .RST_N(RST_N), .EN(EN), .start(start), .mode(mode), .opnd(opnd),
      .X(X), .Y(Y), .D(D), .S(S), .DBR(DBR), .e6502(e6502),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdy(mem_rdy), .mem_din(mem_din),
      .busy(busy), .ea(ea), .ea_valid(ea_valid), .page_cross(page_cross)
   );

   assign mem_din = mem[mem_addr[15:0]];

   always @(posedge CLK)
      if (RST_N && EN && mem_req && mem_rdy)
         rd_log.push_back(mem_addr[15:0]);

   typedef struct {
      string       name;
      logic [2:0]  mode;
      logic [15:0] opnd, x, y, d, s;
      logic [7:0]  dbr;
      logic        e;
      logic [23:0] ea;
      logic        pc;
      int          lat;
      int          nrd;
      logic [15:0] r0, r1, r2;
   } vec_t;

   vec_t vecs [12];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input string nm, input logic [2:0] md, input logic [15:0] op,
                               input logic [15:0] x, input logic [15:0] y, input logic [15:0] d,
                               input logic [15:0] s, input logic [7:0] dbr, input logic e,
                               input logic [23:0] exp_ea, input logic pc, input int lat,
                               input int nrd, input logic [15:0] r0, input logic [15:0] r1,
                               input logic [15:0] r2);
      vec_t v;
      v.name = nm; v.mode = md; v.opnd = op; v.x = x; v.y = y; v.d = d; v.s = s;
      v.dbr = dbr; v.e = e; v.ea = exp_ea; v.pc = pc; v.lat = lat; v.nrd = nrd;
      v.r0 = r0; v.r1 = r1; v.r2 = r2;
      return v;
   endfunction

   // Called #1 after a rising edge; returns #1 after the accepting edge.
   task automatic do_start(input vec_t v);
      mode = v.mode; opnd = v.opnd; X = v.x; Y = v.y; D = v.d; S = v.s;
      DBR = v.dbr; e6502 = v.e; start = 1'b1;
      rd_log.delete();
      @(posedge CLK);
      #1 start = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      int lat;
      bit seen;
      logic [15:0] exp_rd;
      do_start(v);
      lat = 0;
      seen = 0;
      while (!seen && lat < 40) begin
         @(posedge CLK);
         lat++;
         #1 seen = ea_valid;
      end
      if (!seen) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s timeout: no ea_valid within %0d cycles, expected %0d", v.name, lat, v.lat);
         return;
      end
      chk({v.name, " latency"}, 32'(lat), 32'(v.lat));
      chk({v.name, " ea"}, {8'h00, ea}, {8'h00, v.ea});
      chk({v.name, " page_cross"}, {31'd0, page_cross}, {31'd0, v.pc});
      chk({v.name, " reads"}, 32'(rd_log.size()), 32'(v.nrd));
      for (int i = 0; i < v.nrd && i < rd_log.size(); i++) begin
         exp_rd = (i == 0) ? v.r0 : (i == 1) ? v.r1 : v.r2;
         chk($sformatf("%s read%0d addr", v.name, i), {16'h0, rd_log[i]}, {16'h0, exp_rd});
      end
      @(posedge CLK);
      #1;
      chk({v.name, " pulse"}, {31'd0, ea_valid}, 32'd0);
      chk({v.name, " idle"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int pulses, changes;
      logic [23:0] addr0, last_ea;

      RST_N = 1'b0; EN = 1'b1; start = 1'b0; mode = 3'd0; opnd = 16'h0;
      X = 16'h0; Y = 16'h0; D = 16'h0; S = 16'h0; DBR = 8'h0; e6502 = 1'b0; mem_rdy = 1'b1;

      mem[16'h0110] = 8'h34; mem[16'h0111] = 8'h12;
      mem[16'hFFFF] = 8'h00; mem[16'h0000] = 8'h80; mem[16'h0001] = 8'h05;
      mem[16'h00FF] = 8'hCD;
      mem[16'h12FF] = 8'h11; mem[16'h1200] = 8'h22; mem[16'h1300] = 8'h99;
      mem[16'h2115] = 8'h78; mem[16'h2116] = 8'h56;
      mem[16'h01F3] = 8'h20; mem[16'h01F4] = 8'h40;
      mem[16'h0040] = 8'hFF; mem[16'h0041] = 8'hFF;

      //            name            md    opnd     X        Y        D        S        DBR    e  ea          pc lat nrd r0       r1       r2
      vecs[0]  = mk("abs_x_cross",  3'd0, 16'hFFF0, 16'h0020, 16'h0000, 16'h0000, 16'h0000, 8'h12, 0, 24'h130010, 1, 2, 0, 16'h0,    16'h0,    16'h0);
      vecs[1]  = mk("abs_y_bank",   3'd1, 16'hFFFF, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 8'h7F, 0, 24'h800000, 1, 2, 0, 16'h0,    16'h0,    16'h0);
      vecs[2]  = mk("abs_y_emu",    3'd1, 16'h1000, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 8'h01, 1, 24'h011034, 0, 2, 0, 16'h0,    16'h0,    16'h0);
      vecs[3]  = mk("abs_x_wrap",   3'd0, 16'hFFFF, 16'h0002, 16'h0000, 16'h0000, 16'h0000, 8'hFF, 0, 24'h000001, 1, 2, 0, 16'h0,    16'h0,    16'h0);
      vecs[4]  = mk("dp_x_wrap",    3'd2, 16'h0080, 16'h0090, 16'h0000, 16'hFF00, 16'h0000, 8'h55, 0, 24'h000010, 0, 2, 0, 16'h0,    16'h0,    16'h0);
      vecs[5]  = mk("dp_ind_y",     3'd4, 16'h0010, 16'h0000, 16'h0005, 16'h0100, 16'h0000, 8'h7E, 0, 24'h7E1239, 0, 6, 2, 16'h0110, 16'h0111, 16'h0);
      vecs[6]  = mk("dp_ind_long",  3'd5, 16'h00FF, 16'h0000, 16'h0000, 16'hFF00, 16'h0000, 8'h33, 0, 24'h058000, 0, 6, 3, 16'hFFFF, 16'h0000, 16'h0001);
      vecs[7]  = mk("dp_ind_emu0",  3'd3, 16'h00FF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 8'h22, 1, 24'h2280CD, 0, 5, 2, 16'h00FF, 16'h0000, 16'h0);
      vecs[8]  = mk("dp_ind_pgwrap",3'd3, 16'h00FF, 16'h0000, 16'h0000, 16'h1200, 16'h0000, 8'h33, 1, 24'h332211, 0, 5, 2, 16'h12FF, 16'h1200, 16'h0);
      vecs[9]  = mk("dp_ind_native",3'd3, 16'h00FF, 16'h0000, 16'h0000, 16'h1200, 16'h0000, 8'h33, 0, 24'h339911, 0, 5, 2, 16'h12FF, 16'h1300, 16'h0);
      vecs[10] = mk("dp_x_ind",     3'd6, 16'h0010, 16'h0105, 16'h0000, 16'h2000, 16'h0000, 8'h01, 0, 24'h015678, 0, 5, 2, 16'h2115, 16'h2116, 16'h0);
      vecs[11] = mk("sr_ind_y",     3'd7, 16'h0003, 16'h0000, 16'h00F0, 16'h0000, 16'h01F0, 8'h02, 0, 24'h024110, 1, 6, 2, 16'h01F3, 16'h01F4, 16'h0);

      repeat (3) @(posedge CLK);
      #1;
      chk("rst mem_req", {31'd0, mem_req}, 32'd0);
      chk("rst mem_addr", {8'd0, mem_addr}, 32'd0);
      chk("rst ea", {8'd0, ea}, 32'd0);
      chk("rst ea_valid", {31'd0, ea_valid}, 32'd0);
      chk("rst page_cross", {31'd0, page_cross}, 32'd0);
      chk("rst busy", {31'd0, busy}, 32'd0);
      RST_N = 1'b1;
      @(posedge CLK);
      #1;

      for (int i = 0; i < 12; i++)
         run_vec(vecs[i]);
      run_vec(mk("ind_y_carry", 3'd4, 16'h0040, 16'h0, 16'h0001, 16'h0000, 16'h0, 8'h7E, 0,
                 24'h7F0000, 1, 6, 2, 16'h0040, 16'h0041, 16'h0));

      // Start with EN low is not accepted; EN low mid-operation freezes progress.
      EN = 1'b0; start = 1'b1;
      @(posedge CLK);
      #1 start = 1'b0;
      chk("en0 no accept", {31'd0, busy}, 32'd0);
      EN = 1'b1;
      do_start(vecs[0]);
      EN = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      chk("en0 frozen busy", {31'd0, busy}, 32'd1);
      chk("en0 frozen valid", {31'd0, ea_valid}, 32'd0);
      EN = 1'b1;
      @(posedge CLK);
      #1 chk("en1 first edge", {31'd0, ea_valid}, 32'd0);
      @(posedge CLK);
      #1 chk("en1 second edge", {31'd0, ea_valid}, 32'd1);
      chk("en ea", {8'd0, ea}, 32'h130010);
      @(posedge CLK);
      #1;

      // Memory stall: address holds, start during FETCH is dropped, one result only.
      mem_rdy = 1'b0;
      do_start(vecs[5]);
      @(posedge CLK);
      #1 addr0 = mem_addr;
      chk("stall first addr", {8'd0, addr0}, 32'h000110);
      changes = 0;
      for (int c = 0; c < 5; c++) begin
         if (c == 2) begin
            mode = 3'd0; start = 1'b1;
         end
         @(posedge CLK);
         #1 start = 1'b0;
         if (mem_addr !== addr0 || mem_req !== 1'b1) changes++;
      end
      chk("stall addr stable", 32'(changes), 32'd0);
      mem_rdy = 1'b1;
      pulses = 0;
      last_ea = '0;
      for (int c = 0; c < 20; c++) begin
         @(posedge CLK);
         #1;
         if (ea_valid) begin
            pulses++;
            last_ea = ea;
         end
      end
      chk("stall single ea_valid", 32'(pulses), 32'd1);
      chk("stall ea", {8'd0, last_ea}, 32'h7E1239);
      chk("stall idle after", {31'd0, busy}, 32'd0);

      // Reset during the second pointer byte abandons the read.
      do_start(vecs[6]);
      @(posedge CLK);
      @(posedge CLK);
      #1 chk("rst2 second byte addr", {8'd0, mem_addr}, 32'h000000);
      RST_N = 1'b0;
      @(posedge CLK);
      #1;
      chk("rst2 mem_req", {31'd0, mem_req}, 32'd0);
      chk("rst2 busy", {31'd0, busy}, 32'd0);
      chk("rst2 ea", {8'd0, ea}, 32'd0);
      RST_N = 1'b1;
      @(posedge CLK);
      #1;
      chk("rst2 still idle", {31'd0, busy | mem_req}, 32'd0);
      run_vec(vecs[5]);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
